// File: rtl/fluid_dose_sequencer_pkg.sv
// Shared types for the fluid dose sequencer: state enumeration, valve bit
// indices, default timer width and the per-state output decode.
// Optional build macro: FLUSH_STAGE_EN adds the FLUSH state.
package fluid_seq_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    // Bit positions within valve_oh
    localparam int unsigned SOLN1 = 0;
    localparam int unsigned SOLN2 = 1;
    localparam int unsigned SOLN3 = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOSE1 = 3'd1,
        DOSE2 = 3'd2,
        MIX0  = 3'd3,
        DOSE3 = 3'd4,
        MIX1  = 3'd5,
        DRAIN = 3'd6
`ifdef FLUSH_STAGE_EN
        ,
        FLUSH = 3'd7
`endif
    } seq_state_t;

    typedef struct packed {
        logic [2:0] valve_oh;
        logic       pump_en;
        logic       out_valve;
        logic       waste_valve;
    } seq_out_t;

    // Valve/pump pattern driven while the sequencer sits in state s
    function automatic seq_out_t state_outputs(input seq_state_t s);
        seq_out_t o;
        o = '0;
        case (s)
            DOSE1: begin o.valve_oh[SOLN1] = 1'b1; o.pump_en = 1'b1; end
            DOSE2: begin o.valve_oh[SOLN2] = 1'b1; o.pump_en = 1'b1; end
            DOSE3: begin o.valve_oh[SOLN3] = 1'b1; o.pump_en = 1'b1; end
            DRAIN: begin o.out_valve = 1'b1;       o.pump_en = 1'b1; end
`ifdef FLUSH_STAGE_EN
            FLUSH: begin o.waste_valve = 1'b1;     o.pump_en = 1'b1; end
`endif
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fluid_dose_sequencer_if.sv
// Control/status bundle between a host and the fluid dose sequencer.
// master = host side, slave = sequencer side.
interface fluid_dose_sequencer_if
    import fluid_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] dose1_cyc;
    logic [CNT_W-1:0] dose2_cyc;
    logic [CNT_W-1:0] dose3_cyc;
    logic [CNT_W-1:0] mix0_cyc;
    logic [CNT_W-1:0] mix1_cyc;
    logic [CNT_W-1:0] drain_cyc;
    logic [2:0]       valve_oh;
    logic             pump_en;
    logic             out_valve;
    logic             waste_valve;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, abort,
        output dose1_cyc, dose2_cyc, dose3_cyc, mix0_cyc, mix1_cyc, drain_cyc,
        input  valve_oh, pump_en, out_valve, waste_valve, busy, done, aborted
    );

    modport slave (
        input  start, abort,
        input  dose1_cyc, dose2_cyc, dose3_cyc, mix0_cyc, mix1_cyc, drain_cyc,
        output valve_oh, pump_en, out_valve, waste_valve, busy, done, aborted
    );

endinterface

// File: rtl/fluid_dose_sequencer_dwell_timer.sv
// Dwell timer: non-wrapping down-counter. load_i captures value_i;
// otherwise the count decrements until it sits at zero. expired_o is high
// while the count is zero.
module dwell_timer
    import fluid_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins, else saturating decrement toward zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/fluid_dose_sequencer.sv
// Fluid dose sequencer: runs DOSE1, DOSE2, MIX0, DOSE3, MIX1, DRAIN (and
// FLUSH when built with FLUSH_STAGE_EN) with per-stage dwell times captured
// at start. All outputs are registered from the next state so they are
// valid in the first cycle of each state.
module fluid_dose_sequencer
    import fluid_seq_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEFAULT,
    parameter int unsigned FLUSH_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fluid_dose_sequencer_if.slave bus
);

    // Timer reload value for a stage of n cycles (0 behaves as 1)
    function automatic logic [CNT_W-1:0] dwell_load(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : (n - CNT_W'(1));
    endfunction

`ifdef FLUSH_STAGE_EN
    localparam logic [CNT_W-1:0] FLUSH_LOAD =
        (FLUSH_CYC == 0) ? '0 : CNT_W'(FLUSH_CYC - 1);
`endif

    seq_state_t       state_q, state_d;
    logic             tmr_load, tmr_expired;
    logic [CNT_W-1:0] tmr_value;
    logic             latch_en;
    logic             done_d, aborted_d;

    // DOSE1's duration goes straight into the timer on the start edge,
    // so only the later five stages need a held copy.
    logic [CNT_W-1:0] dose2_q, dose3_q, mix0_q, mix1_q, drain_q;

    seq_out_t out_q;
    logic     busy_q, done_q, aborted_q;

    dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .value_i   (tmr_value),
        .expired_o (tmr_expired)
    );

    // Next-state, timer reload and completion/abort pulse decode
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        latch_en  = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = DOSE1;
                    latch_en  = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = dwell_load(bus.dose1_cyc);
                end
            end
            default: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (tmr_expired) begin
                    case (state_q)
                        DOSE1: begin state_d = DOSE2; tmr_value = dwell_load(dose2_q); end
                        DOSE2: begin state_d = MIX0;  tmr_value = dwell_load(mix0_q);  end
                        MIX0:  begin state_d = DOSE3; tmr_value = dwell_load(dose3_q); end
                        DOSE3: begin state_d = MIX1;  tmr_value = dwell_load(mix1_q);  end
                        MIX1:  begin state_d = DRAIN; tmr_value = dwell_load(drain_q); end
`ifdef FLUSH_STAGE_EN
                        DRAIN: begin state_d = FLUSH; tmr_value = FLUSH_LOAD; end
`endif
                        default: state_d = IDLE;
                    endcase
                    tmr_load = (state_d != IDLE);
                    done_d   = (state_d == IDLE);
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the stage durations when a sequence is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dose2_q <= '0;
            dose3_q <= '0;
            mix0_q  <= '0;
            mix1_q  <= '0;
            drain_q <= '0;
        end else if (latch_en) begin
            dose2_q <= bus.dose2_cyc;
            dose3_q <= bus.dose3_cyc;
            mix0_q  <= bus.mix0_cyc;
            mix1_q  <= bus.mix1_cyc;
            drain_q <= bus.drain_cyc;
        end
    end

    // Registered outputs decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            out_q     <= state_outputs(state_d);
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.valve_oh  = out_q.valve_oh;
    assign bus.pump_en   = out_q.pump_en;
    assign bus.out_valve = out_q.out_valve;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

`ifdef FLUSH_STAGE_EN
    assign bus.waste_valve = out_q.waste_valve;
`else
    logic unused_flush;
    assign unused_flush  = (FLUSH_CYC != 0) ^ out_q.waste_valve;
    assign bus.waste_valve = 1'b0;
`endif

endmodule
